// File: rtl/pcs_tx_oset_sequencer.sv
// pcs_tx_oset_sequencer: selects the 1000BASE-X ordered set for each transmit code-group slot
module pcs_tx_oset_sequencer #(
    parameter int MIN_IDLE = 1
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [7:0] TXD,
    output logic [2:0] tx_o_set,
    output logic [7:0] tx_data,
    output logic       tx_even,
    output logic       transmitting,
    output logic       TX_OSET_indicate
);
    // state codes double as the tx_o_set encoding, except EPD_R3 which shows as /R/
    localparam logic [2:0] IDLE_K = 3'd0;
    localparam logic [2:0] IDLE_D = 3'd1;
    localparam logic [2:0] SOP    = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] EOP_T  = 3'd4;
    localparam logic [2:0] EPD_R  = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;
    localparam logic [2:0] EPD_R3 = 3'd7;
    localparam logic [3:0] IDLE_LOAD = 4'(MIN_IDLE - 1);

    logic [2:0] r_state;
    logic [2:0] w_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_even;
    logic [2:0] r_o_set;
    logic [7:0] r_data;
    logic       r_tx;
    logic       r_ind;

    // next-slot decision; a start needs the counter already at zero so MIN_IDLE full /I/ sets precede /S/
    always_comb begin
        w_nxt     = IDLE_K;
        w_cnt_nxt = r_cnt;
        case (r_state)
            IDLE_K: w_nxt = IDLE_D;
            IDLE_D: begin
                w_nxt     = (TX_EN && r_cnt == 4'd0) ? SOP : IDLE_K;
                w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end
            SOP, DATA, ERR: w_nxt = !TX_EN ? EOP_T : (TX_ER ? ERR : DATA);
            EOP_T: w_nxt = EPD_R;
            EPD_R: begin
                w_nxt     = (!TX_EN && TX_ER) ? EPD_R : (r_even ? EPD_R3 : IDLE_K);
                w_cnt_nxt = (w_nxt == IDLE_K) ? IDLE_LOAD : r_cnt;
            end
            default: begin
                w_nxt     = IDLE_K;
                w_cnt_nxt = IDLE_LOAD;
            end
        endcase
    end

    // state, parity and registered slot outputs derived from the state being entered
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_state <= IDLE_K;
            r_cnt   <= 4'd0;
            r_even  <= 1'b1;
            r_o_set <= 3'd0;
            r_data  <= 8'h00;
            r_tx    <= 1'b0;
            r_ind   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_even  <= ~r_even;
            r_o_set <= (w_nxt == EPD_R3) ? EPD_R : w_nxt;
            r_data  <= (w_nxt == DATA) ? TXD : 8'h00;
            r_tx    <= (w_nxt == SOP) || (w_nxt == DATA) || (w_nxt == ERR) || (w_nxt == EOP_T);
            r_ind   <= (w_nxt != IDLE_K);
        end
    end

    assign tx_o_set         = r_o_set;
    assign tx_data          = r_data;
    assign tx_even          = r_even;
    assign transmitting     = r_tx;
    assign TX_OSET_indicate = r_ind;

    // idle sequence alignment: IDLE_K must only ever occupy an even slot
    a_idle_k_even: assert property (@(posedge GTX_CLK) disable iff (mr_main_reset)
        (r_state != IDLE_K) || r_even);
endmodule

// File: tb/tb_pcs_tx_oset_sequencer.sv
// tb_pcs_tx_oset_sequencer: scoreboard bench for the ordered-set sequencer
module tb_pcs_tx_oset_sequencer;
    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic       TX_EN = 1'b0;
    logic       TX_ER = 1'b0;
    logic [7:0] TXD = 8'h00;
    logic [2:0] o_set1, o_set2;
    logic [7:0] data1, data2;
    logic       even1, even2, tx1, tx2, ind1, ind2;
    logic [12:0] obs1, obs2;
    logic [12:0] sb[$];
    logic [22:0] rows[$];
    int checks = 0;
    int errors = 0;

    pcs_tx_oset_sequencer #(.MIN_IDLE(1)) u1 (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
        .tx_o_set(o_set1), .tx_data(data1), .tx_even(even1), .transmitting(tx1), .TX_OSET_indicate(ind1));

    pcs_tx_oset_sequencer #(.MIN_IDLE(2)) u2 (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
        .tx_o_set(o_set2), .tx_data(data2), .tx_even(even2), .transmitting(tx2), .TX_OSET_indicate(ind2));

    assign obs1 = {o_set1, data1, even1, tx1, ind1};
    assign obs2 = {o_set2, data2, even2, tx2, ind2};

    always #5 GTX_CLK = ~GTX_CLK;

    // expected slot packed as {o_set, data, even, transmitting, indicate}
    function automatic logic [12:0] exp_slot(int o, int d, int ev, int tx, int ind);
        return {o[2:0], d[7:0], ev[0], tx[0], ind[0]};
    endfunction

    // one cycle of stimulus {TX_EN, TX_ER, TXD} plus the slot it must produce
    function automatic logic [22:0] row(int en, int er, int d, int o, int dd, int ev, int tx, int ind);
        return {en[0], er[0], d[7:0], exp_slot(o, dd, ev, tx, ind)};
    endfunction

    task automatic drive(input logic [22:0] r);
        TX_EN = r[22];
        TX_ER = r[21];
        TXD   = r[20:13];
        sb.push_back(r[12:0]);
    endtask

    task automatic apply_reset();
        mr_main_reset = 1'b1;
        TX_EN = 1'b0;
        TX_ER = 1'b0;
        TXD   = 8'h00;
        @(posedge GTX_CLK);
        #1;
        mr_main_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        e = exp_slot(0, 0, 1, 0, 0);
        mr_main_reset = 1'b1;
        @(posedge GTX_CLK);
        #1;
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL reset_u1 got %h exp %h", obs1, e); end
        checks++;
        if (obs2 !== e) begin errors++; $display("FAIL reset_u2 got %h exp %h", obs2, e); end
        TX_EN = 1'b1;
        TXD   = 8'hFF;
        @(posedge GTX_CLK);
        #1;
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL reset_hold_u1 got %h exp %h", obs1, e); end
        checks++;
        if (obs2 !== e) begin errors++; $display("FAIL reset_hold_u2 got %h exp %h", obs2, e); end
    endtask

    task automatic test_idle();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        for (int k = 1; k <= 8; k++)
            rows.push_back((k % 2) ? row(0, 0, 0, 1, 0, 0, 0, 1) : row(0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL idle[%0d] got %h exp %h", i, obs1, e); end
        end
    endtask

    task automatic test_packet_even_end();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        rows.push_back(row(1, 0, 8'hAA, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h55, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h01, 3, 8'h01, 0, 1, 1));
        rows.push_back(row(1, 0, 8'h03, 3, 8'h03, 1, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 4, 0,     0, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     1, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 0, 0,     1, 0, 0));
        rows.push_back(row(0, 0, 8'h00, 1, 0,     0, 0, 1));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL pkt_even[%0d] got %h exp %h", i, obs1, e); end
        end
    endtask

    task automatic test_packet_odd_end_and_single();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        rows.push_back(row(0, 0, 8'h00, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h55, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h01, 3, 8'h01, 0, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 4, 0,     1, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h77, 0, 0,     1, 0, 0));
        rows.push_back(row(1, 0, 8'h77, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h12, 2, 0,     1, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 4, 0,     0, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     1, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 0, 0,     1, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL pkt_odd[%0d] got %h exp %h", i, obs1, e); end
        end
    endtask

    task automatic test_error();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        rows.push_back(row(0, 0, 8'h00, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h55, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h9A, 3, 8'h9A, 0, 1, 1));
        rows.push_back(row(1, 1, 8'hB5, 6, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h42, 3, 8'h42, 0, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 4, 0,     1, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 0, 0,     1, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL error[%0d] got %h exp %h", i, obs1, e); end
        end
    endtask

    task automatic test_carrier_ext();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        rows.push_back(row(0, 0, 8'h00, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h55, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'hC3, 3, 8'hC3, 0, 1, 1));
        rows.push_back(row(0, 1, 8'h00, 4, 0,     1, 1, 1));
        rows.push_back(row(0, 1, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(0, 1, 8'h00, 5, 0,     1, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 5, 0,     0, 0, 1));
        rows.push_back(row(0, 0, 8'h00, 0, 0,     1, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL carrier_ext[%0d] got %h exp %h", i, obs1, e); end
        end
    endtask

    task automatic test_back_to_back_min_idle2();
        logic [12:0] e;
        apply_reset();
        rows.delete();
        rows.push_back(row(1, 0, 8'h55, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h11, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h22, 3, 8'h22, 0, 1, 1));
        rows.push_back(row(0, 0, 8'h00, 4, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h33, 5, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h33, 0, 0,     1, 0, 0));
        rows.push_back(row(1, 0, 8'h33, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h33, 0, 0,     1, 0, 0));
        rows.push_back(row(1, 0, 8'h33, 1, 0,     0, 0, 1));
        rows.push_back(row(1, 0, 8'h44, 2, 0,     1, 1, 1));
        rows.push_back(row(1, 0, 8'h5A, 3, 8'h5A, 0, 1, 1));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs2 !== e) begin errors++; $display("FAIL b2b_idle2[%0d] got %h exp %h", i, obs2, e); end
        end
        #2;
        mr_main_reset = 1'b1;
        TXD = 8'h66;
        #1;
        e = exp_slot(0, 0, 1, 0, 0);
        checks++;
        if (obs2 !== e) begin errors++; $display("FAIL async_reset got %h exp %h", obs2, e); end
        @(posedge GTX_CLK);
        #1;
        checks++;
        if (obs2 !== e) begin errors++; $display("FAIL reset_next got %h exp %h", obs2, e); end
        mr_main_reset = 1'b0;
        rows.delete();
        rows.push_back(row(1, 0, 8'h66, 1, 0, 0, 0, 1));
        rows.push_back(row(1, 0, 8'h77, 2, 0, 1, 1, 1));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs2 !== e) begin errors++; $display("FAIL post_reset[%0d] got %h exp %h", i, obs2, e); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_packet_even_end();
        test_packet_odd_end_and_single();
        test_error();
        test_carrier_ext();
        test_back_to_back_min_idle2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
